// File: rtl/booth16_multiple_gen_if.sv
// Operand/multiple handshake bundle for booth16_multiple_gen.
// Every output vector carries NUM_PORTS packed copies.
interface booth16_multiple_gen_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 1
);
  logic                  iVld;
  logic                  iRdy;
  logic                  iSigned;
  logic [DATA_W-1:0]     iDat;
  logic                  oVld;
  logic                  oRdy;
  logic [NUM_PORTS-1:0][DATA_W:0]   oDat1X;
  logic [NUM_PORTS-1:0][DATA_W+2:0] oDat3X;
  logic [NUM_PORTS-1:0][DATA_W+3:0] oDat5X;
  logic [NUM_PORTS-1:0][DATA_W+3:0] oDat7X;

  modport master (
    output iVld, iSigned, iDat, oRdy,
    input  iRdy, oVld,
    input  oDat1X, oDat3X, oDat5X, oDat7X
  );

  modport slave (
    input  iVld, iSigned, iDat, oRdy,
    output iRdy, oVld,
    output oDat1X, oDat3X, oDat5X, oDat7X
  );
endinterface

// File: rtl/booth16_multiple_gen.sv
// Radix-16 odd-multiple precompute: two-stage elastic pipe
// producing 1X/3X/5X/7X, replicated per output port.
module booth16_multiple_gen #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 1
) (
  input  logic clk,
  input  logic rst,
  booth16_multiple_gen_if.slave bus
);

  localparam int W = DATA_W;

  logic         s1_v;
  logic         s2_v;
  logic [W:0]   s1_x;
  logic [W:0]   x_in;
  logic         acc;
  logic         s2_load;

  logic [W+2:0] e3;
  logic [W+3:0] e4;
  logic [W+2:0] p3;
  logic [W+3:0] p5;
  logic [W+3:0] p7;

  assign s2_load  = s1_v & (~s2_v | bus.oRdy);
  assign bus.iRdy = rst & (~s1_v | s2_load);
  assign acc      = bus.iVld & bus.iRdy;
  assign bus.oVld = s2_v;

  // mode is folded into the extra bit, so S1 needs no separate flag
  assign x_in = {bus.iSigned & bus.iDat[W-1], bus.iDat};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_x <= '0;
    end else begin
      if (acc)
        s1_v <= 1'b1;
      else if (s2_load)
        s1_v <= 1'b0;
      if (acc)
        s1_x <= x_in;
      if (s2_load)
        s2_v <= 1'b1;
      else if (bus.oRdy)
        s2_v <= 1'b0;
    end
  end

  assign e3 = {{2{s1_x[W]}}, s1_x};
  assign e4 = {{3{s1_x[W]}}, s1_x};
  assign p3 = {e3[W+1:0], 1'b0} + e3;
  assign p5 = {e4[W+1:0], 2'b00} + e4;
  assign p7 = {s1_x, 3'b000} - e4;

  // one private register set per port keeps fanout isolated
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [W:0]   r1;
    logic [W+2:0] r3;
    logic [W+3:0] r5;
    logic [W+3:0] r7;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r1 <= '0;
        r3 <= '0;
        r5 <= '0;
        r7 <= '0;
      end else if (s2_load) begin
        r1 <= s1_x;
        r3 <= p3;
        r5 <= p5;
        r7 <= p7;
      end
    end

    assign bus.oDat1X[p] = r1;
    assign bus.oDat3X[p] = r3;
    assign bus.oDat5X[p] = r5;
    assign bus.oDat7X[p] = r7;
  end

endmodule
